trojan_resp_misr: RTL and testbench

Response compactor for the golden-model/Trojan-detection flow. It sits directly downstream of the combinational benchmark wrapper (178-bit `in_val` in, 123-bit `out_val` out). It consumes one `out_val` response per valid cycle and folds it into a 32-bit multiple-input signature register (MISR). After a programmed number of vectors it compares the signature against a golden value and reports pass/fail, so a Trojan-infected netlist is flagged by a signature mismatch.

---
 rtl/trojan_resp_misr.sv | 142 ++++++++++++++
 tb/tb_trojan_resp_misr.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trojan_resp_misr.sv
// Response compactor: folds each wrapper response word into a 32-bit MISR and,
// after a programmed number of responses, compares the signature to a golden value.
module trojan_resp_misr #(
  parameter int unsigned       OUT_W = 123,
  parameter int unsigned       SIG_W = 32,
  parameter logic [SIG_W-1:0]  POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             resp_valid,
  input  logic [OUT_W-1:0] resp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      vec_count
);

  localparam int unsigned NumChunks = (OUT_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PadW      = NumChunks * SIG_W;

  typedef enum logic [1:0] {StIdle, StRun, StCmp} state_e;

  state_e             state_q, state_d;
  logic [15:0]        num_q, num_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;

  logic [PadW-1:0]    resp_pad;
  logic [SIG_W-1:0]   fold;
  logic [SIG_W-1:0]   sig_next;
  logic [15:0]        cnt_inc;
  logic               accept;
  logic               start_ok;

  // Zero-pad the response to a whole number of signature-wide chunks.
  always_comb begin
    resp_pad              = '0;
    resp_pad[OUT_W-1:0]   = resp_data;
  end

  // XOR all chunks together; chunk 0 is the least significant slice.
  always_comb begin
    fold = '0;
    for (int i = 0; i < NumChunks; i++) begin
      fold = fold ^ resp_pad[i*SIG_W +: SIG_W];
    end
  end

  // One MISR step: shift left, feed back the polynomial on MSB, inject the fold.
  always_comb begin
    sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
  end

  assign accept   = (state_q == StRun) && resp_valid;
  assign start_ok = (state_q == StIdle) && start;
  assign cnt_inc  = cnt_q + 16'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (num_vec == 16'd0) ? StCmp : StRun;
        end
      end
      StRun: begin
        if (accept && (cnt_inc == num_q)) begin
          state_d = StCmp;
        end
      end
      StCmp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == StRun) || (state_q == StCmp);
  end

  // Datapath next-state: run setup, response accumulation and the compare.
  always_comb begin
    num_d  = num_q;
    sig_d  = sig_q;
    cnt_d  = cnt_q;
    pass_d = pass_q;
    done_d = 1'b0;
    if (start_ok) begin
      num_d  = num_vec;
      sig_d  = SEED;
      cnt_d  = 16'd0;
      pass_d = 1'b0;
    end else if (accept) begin
      sig_d = sig_next;
      cnt_d = cnt_inc;
    end
    if (state_q == StCmp) begin
      pass_d = (sig_q == golden_sig);
      done_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q  <= 16'd0;
      sig_q  <= '0;
      cnt_q  <= 16'd0;
      pass_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      num_q  <= num_d;
      sig_q  <= sig_d;
      cnt_q  <= cnt_d;
      pass_q <= pass_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_trojan_resp_misr.sv
// Self-checking bench for trojan_resp_misr: scoreboard of model signatures.
module tb_trojan_resp_misr;

  localparam int          OUT_W = 123;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [15:0]       num_vec;
  logic [31:0]       golden_sig;
  logic              resp_valid;
  logic [OUT_W-1:0]  resp_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic [31:0]       signature;
  logic [15:0]       vec_count;

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    logic [15:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  logic [OUT_W-1:0] mem [256];
  int               n_checks;
  int               n_fail;

  trojan_resp_misr #(
    .OUT_W(OUT_W),
    .SIG_W(32),
    .POLY (POLY),
    .SEED (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .golden_sig(golden_sig),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .vec_count (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-wise fold (bit i lands on position i mod 32), then the MISR step.
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [OUT_W-1:0] d);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < OUT_W; i++) f[i % 32] = f[i % 32] ^ d[i];
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [31:0] model_sig(input int n);
    logic [31:0] s;
    s = SEED;
    for (int i = 0; i < n; i++) s = model_step(s, mem[i]);
    return s;
  endfunction

  function automatic logic [OUT_W-1:0] rand_word();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[OUT_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one run from mem[]; mode 1 inserts gaps (1,0,0,...) and a stray start in RUN.
  task automatic run_stream(input int n, input logic [31:0] gold, input int mode,
                            output bit got_done, output logic p, output logic [31:0] s,
                            output logic [15:0] c, output int lat, output bit start_ok);
    int idx;
    int cyc;
    int last_acc;
    start      = 1'b1;
    num_vec    = n[15:0];
    golden_sig = gold;
    resp_valid = 1'b0;
    tick();
    start    = 1'b0;
    start_ok = (busy === 1'b1) && (signature === SEED) && (vec_count === 16'd0) &&
               (done === 1'b0) && (pass === 1'b0);
    idx      = 0;
    cyc      = 0;
    last_acc = 0;
    got_done = 1'b0;
    lat      = -1;
    p        = 1'bx;
    s        = 'x;
    c        = 'x;
    while (!got_done && cyc < 2000) begin
      if (idx < n && (mode == 0 || cyc % 3 == 0)) begin
        resp_valid = 1'b1;
        resp_data  = mem[idx];
      end else begin
        resp_valid = 1'b0;
        resp_data  = rand_word();
      end
      start = (mode == 1 && cyc == 2) ? 1'b1 : 1'b0;
      tick();
      cyc++;
      if (resp_valid) begin
        idx++;
        last_acc = cyc;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        lat      = cyc - last_acc;
        p        = pass;
        s        = signature;
        c        = vec_count;
      end
    end
    resp_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start      = 1'($urandom);
      num_vec    = 16'($urandom);
      golden_sig = $urandom;
      resp_valid = 1'($urandom);
      resp_data  = rand_word();
      tick();
    end
    n_checks++;
    if ({busy, done, pass, signature, vec_count} !== '0) begin
      $display("FAIL reset_active: busy=%b done=%b pass=%b sig=%h cnt=%0d, required all 0",
               busy, done, pass, signature, vec_count);
      n_fail++;
    end
    start      = 1'b0;
    resp_valid = 1'b0;
    rst_n      = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if ({busy, done, pass, signature, vec_count} !== '0) begin
      $display("FAIL reset_release: busy=%b done=%b pass=%b sig=%h cnt=%0d, required all 0",
               busy, done, pass, signature, vec_count);
      n_fail++;
    end
  endtask

  task automatic check_run(input string name, input int n, input logic [31:0] gold,
                           input int mode);
    bit          got;
    bit          st_ok;
    logic        p;
    logic [31:0] s;
    logic [15:0] c;
    int          lat;
    exp_t        e;
    run_stream(n, gold, mode, got, p, s, c, lat, st_ok);
    n_checks++;
    if (!st_ok) begin
      $display("FAIL %s_start: busy=%b sig=%h cnt=%0d done=%b, required busy=1 sig=%h cnt=0",
               name, busy, signature, vec_count, done, SEED);
      n_fail++;
    end
    n_checks++;
    if (!got) begin
      $display("FAIL %s_timeout: no done pulse, required done within budget", name);
      n_fail++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (s !== e.sig || p !== e.pass || c !== e.cnt) begin
      $display("FAIL %s_result: sig=%h pass=%b cnt=%0d, required sig=%h pass=%b cnt=%0d",
               name, s, p, c, e.sig, e.pass, e.cnt);
      n_fail++;
    end
    n_checks++;
    if (lat !== 1 || busy !== 1'b0) begin
      $display("FAIL %s_latency: done %0d edges after last accept busy=%b, required 1 busy=0",
               name, lat, busy);
      n_fail++;
    end
  endtask

  task automatic test_single_zero();
    mem[0] = '0;
    exp_q.push_back('{sig: 32'hFB3EE249, pass: 1'b1, cnt: 16'd1});
    check_run("single_zero", 1, 32'hFB3EE249, 0);
    tick();
    n_checks++;
    if (done !== 1'b0 || pass !== 1'b1 || signature !== 32'hFB3EE249) begin
      $display("FAIL single_zero_after: done=%b pass=%b sig=%h, required done=0 pass=1 sig=fb3ee249",
               done, pass, signature);
      n_fail++;
    end
  endtask

  task automatic test_zero_len();
    exp_q.push_back('{sig: SEED, pass: 1'b1, cnt: 16'd0});
    check_run("zero_len", 0, 32'hFFFFFFFF, 0);
    tick();
  endtask

  task automatic test_trojan();
    logic [31:0] gold;
    for (int i = 0; i < 100; i++) mem[i] = rand_word();
    gold = model_sig(100);
    exp_q.push_back('{sig: gold, pass: (gold == 32'h0), cnt: 16'd100});
    check_run("trojan_capture", 100, 32'h0, 0);
    tick();
    mem[57][122] = ~mem[57][122];
    exp_q.push_back('{sig: model_sig(100), pass: 1'b0, cnt: 16'd100});
    check_run("trojan_flip", 100, gold, 0);
    tick();
    mem[57][122] = ~mem[57][122];
    exp_q.push_back('{sig: gold, pass: 1'b1, cnt: 16'd100});
    check_run("trojan_clean", 100, gold, 0);
    tick();
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 5; i++) mem[i] = rand_word();
    exp_q.push_back('{sig: model_sig(5), pass: 1'b1, cnt: 16'd5});
    check_run("gaps", 5, model_sig(5), 1);
    tick();
  endtask

  task automatic test_idle_hold();
    logic [31:0] s0;
    logic [15:0] c0;
    logic        p0;
    s0 = signature;
    c0 = vec_count;
    p0 = pass;
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1;
      resp_data  = rand_word();
      tick();
    end
    resp_valid = 1'b0;
    n_checks++;
    if (signature !== s0 || vec_count !== c0 || pass !== p0 || busy !== 1'b0) begin
      $display("FAIL idle_hold: sig=%h cnt=%0d pass=%b busy=%b, required sig=%h cnt=%0d pass=%b busy=0",
               signature, vec_count, pass, busy, s0, c0, p0);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) mem[i] = rand_word();
    exp_q.push_back('{sig: model_sig(8), pass: 1'b1, cnt: 16'd8});
    check_run("b2b_first", 8, model_sig(8), 0);
    // Second start is driven right after the done edge; it must be accepted.
    exp_q.push_back('{sig: model_sig(3), pass: 1'b0, cnt: 16'd3});
    check_run("b2b_second", 3, ~model_sig(3), 0);
    tick();
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 10; i++) mem[i] = rand_word();
    start   = 1'b1;
    num_vec = 16'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1;
      resp_data  = mem[i];
      tick();
    end
    resp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, pass, signature, vec_count} !== '0) begin
      $display("FAIL midrun_reset: busy=%b done=%b pass=%b sig=%h cnt=%0d, required all 0",
               busy, done, pass, signature, vec_count);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL midrun_no_done: done=%b busy=%b, required 0 0", done, busy);
        n_fail++;
      end
    end
    rst_n = 1'b1;
    tick();
    exp_q.push_back('{sig: model_sig(10), pass: 1'b1, cnt: 16'd10});
    check_run("midrun_rerun", 10, model_sig(10), 0);
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_vec    = '0;
    golden_sig = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    test_reset();
    test_single_zero();
    test_zero_len();
    test_trojan();
    test_idle_hold();
    test_gaps();
    test_back_to_back();
    test_reset_midrun();
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
